// File: rtl/tlb_mp.sv
// tlb_mp: fully-associative LoongArch TLB with NPORT registered search ports, a registered read port,
// TLBWR/TLBFILL writes and INVTLB. Define TLB_MULTIHIT_CHK_EN to build the s_multi multi-hit detector.
module tlb_mp #(
  parameter int         TLBNUM    = 16,
  parameter int         NPORT     = 2,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  localparam int        IDXW      = $clog2(TLBNUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  // search ports
  input  logic [NPORT-1:0]      s_req,
  input  logic [NPORT*19-1:0]   s_vppn,
  input  logic [NPORT-1:0]      s_va_bit12,
  input  logic [NPORT*10-1:0]   s_asid,
  output logic [NPORT-1:0]      s_valid,
  output logic [NPORT-1:0]      s_found,
  output logic [NPORT*IDXW-1:0] s_index,
  output logic [NPORT*20-1:0]   s_ppn,
  output logic [NPORT*6-1:0]    s_ps,
  output logic [NPORT*2-1:0]    s_plv,
  output logic [NPORT*2-1:0]    s_mat,
  output logic [NPORT-1:0]      s_d,
  output logic [NPORT-1:0]      s_v,
  output logic [NPORT-1:0]      s_multi,
  // read port
  input  logic                  r_req,
  input  logic [IDXW-1:0]       r_index,
  output logic                  r_valid,
  output logic                  r_e,
  output logic [18:0]           r_vppn,
  output logic [5:0]            r_ps,
  output logic [9:0]            r_asid,
  output logic                  r_g,
  output logic [19:0]           r_ppn0,
  output logic [1:0]            r_plv0,
  output logic [1:0]            r_mat0,
  output logic                  r_d0,
  output logic                  r_v0,
  output logic [19:0]           r_ppn1,
  output logic [1:0]            r_plv1,
  output logic [1:0]            r_mat1,
  output logic                  r_d1,
  output logic                  r_v1,
  // write port
  input  logic                  we,
  input  logic                  fill,
  input  logic [IDXW-1:0]       w_index,
  input  logic                  w_e,
  input  logic [18:0]           w_vppn,
  input  logic [5:0]            w_ps,
  input  logic [9:0]            w_asid,
  input  logic                  w_g,
  input  logic [19:0]           w_ppn0,
  input  logic [1:0]            w_plv0,
  input  logic [1:0]            w_mat0,
  input  logic                  w_d0,
  input  logic                  w_v0,
  input  logic [19:0]           w_ppn1,
  input  logic [1:0]            w_plv1,
  input  logic [1:0]            w_mat1,
  input  logic                  w_d1,
  input  logic                  w_v1,
  output logic [IDXW-1:0]       fill_index,
  // invalidate
  input  logic                  invtlb_valid,
  input  logic [4:0]            invtlb_op,
  input  logic [9:0]            invtlb_asid,
  input  logic [18:0]           invtlb_vppn,
  output logic                  invtlb_ill
);

  // ps holds the page-size exponent already normalised to 12 or 22 at write time.
  typedef struct packed {
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } ent_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [1:0]      plv;
    logic [1:0]      mat;
    logic            d;
    logic            v;
  } res_t;

  logic [TLBNUM-1:0] e_q, e_d;
  ent_t              ent_q [TLBNUM];
  ent_t              w_ent;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [IDXW-1:0]   victim, wr_idx, fill_index_q;
  logic [TLBNUM-1:0] hit [NPORT];
  res_t              lk [NPORT];
  res_t              res_q [NPORT];
  logic [NPORT-1:0]  s_valid_q;
  logic              r_valid_q, r_e_q;
  ent_t              r_ent_q;
  logic [TLBNUM-1:0] inv_sel;
  logic              invtlb_ill_q;

  assign w_ent = '{vppn: w_vppn, ps: (w_ps == 6'd22) ? 6'd22 : 6'd12, asid: w_asid, g: w_g,
                   ppn0: w_ppn0, plv0: w_plv0, mat0: w_mat0, d0: w_d0, v0: w_v0,
                   ppn1: w_ppn1, plv1: w_plv1, mat1: w_mat1, d1: w_d1, v1: w_v1};

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      for (int i = 0; i < TLBNUM; i++) begin
        hit[p][i] = e_q[i]
                  && (ent_q[i].vppn[18:10] == s_vppn[p*19+10 +: 9])
                  && ((ent_q[i].ps == 6'd22) || (ent_q[i].vppn[9:0] == s_vppn[p*19 +: 10]))
                  && (ent_q[i].g || (ent_q[i].asid == s_asid[p*10 +: 10]));
      end
    end
  end

  // Scanning from the top down leaves the lowest matching index as the final assignment.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      lk[p] = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (hit[p][i]) begin
          lk[p].found = 1'b1;
          lk[p].idx   = IDXW'(i);
          lk[p].ps    = ent_q[i].ps;
          if ((ent_q[i].ps == 6'd22) ? s_vppn[p*19+9] : s_va_bit12[p]) begin
            lk[p].ppn = ent_q[i].ppn1;
            lk[p].plv = ent_q[i].plv1;
            lk[p].mat = ent_q[i].mat1;
            lk[p].d   = ent_q[i].d1;
            lk[p].v   = ent_q[i].v1;
          end else begin
            lk[p].ppn = ent_q[i].ppn0;
            lk[p].plv = ent_q[i].plv0;
            lk[p].mat = ent_q[i].mat0;
            lk[p].d   = ent_q[i].d0;
            lk[p].v   = ent_q[i].v0;
          end
        end
      end
    end
  end

  always_comb begin
    victim = lfsr_q[IDXW-1:0];
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (!e_q[i]) victim = IDXW'(i);
    end
  end

  assign wr_idx = fill ? victim : w_index;
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  for (genvar gi = 0; gi < TLBNUM; gi++) begin : g_inv
    logic asid_eq, va_eq, sel;
    assign asid_eq = (ent_q[gi].asid == invtlb_asid);
    assign va_eq   = (ent_q[gi].vppn[18:10] == invtlb_vppn[18:10])
                  && ((ent_q[gi].ps == 6'd22) || (ent_q[gi].vppn[9:0] == invtlb_vppn[9:0]));
    always_comb begin
      case (invtlb_op)
        5'd0, 5'd1: sel = 1'b1;
        5'd2:       sel = ent_q[gi].g;
        5'd3:       sel = !ent_q[gi].g;
        5'd4:       sel = !ent_q[gi].g && asid_eq;
        5'd5:       sel = !ent_q[gi].g && asid_eq && va_eq;
        5'd6:       sel = (ent_q[gi].g || asid_eq) && va_eq;
        default:    sel = 1'b0;
      endcase
    end
    assign inv_sel[gi] = sel;
  end

  // INVTLB clears first so a same-cycle write to one of the cleared entries still lands.
  always_comb begin
    e_d = e_q;
    if (invtlb_valid) e_d = e_q & ~inv_sel;
    if (we) e_d[wr_idx] = w_e;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q          <= '0;
      lfsr_q       <= LFSR_SEED;
      fill_index_q <= '0;
      invtlb_ill_q <= 1'b0;
      s_valid_q    <= '0;
      r_valid_q    <= 1'b0;
      r_e_q        <= 1'b0;
      r_ent_q      <= '0;
      for (int p = 0; p < NPORT; p++) res_q[p] <= '0;
    end else begin
      e_q          <= e_d;
      invtlb_ill_q <= invtlb_valid && (invtlb_op > 5'd6);
      if (we && fill) begin
        lfsr_q       <= lfsr_d;
        fill_index_q <= victim;
      end
      // s_req/r_req qualify the inputs for one cycle; results appear as s_valid/r_valid one cycle later.
      s_valid_q <= s_req;
      for (int p = 0; p < NPORT; p++) begin
        if (s_req[p]) res_q[p] <= lk[p];
      end
      r_valid_q <= r_req;
      if (r_req) begin
        r_e_q   <= e_q[r_index];
        r_ent_q <= ent_q[r_index];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) ent_q[wr_idx] <= w_ent;
  end

`ifdef TLB_MULTIHIT_CHK_EN
  logic [NPORT-1:0] multi_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      multi_q <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        if (s_req[p]) multi_q[p] <= ($countones(hit[p]) > 1);
      end
    end
  end
  assign s_multi = multi_q;
`else
  assign s_multi = '0;
`endif

  for (genvar gp = 0; gp < NPORT; gp++) begin : g_out
    assign s_found[gp]               = res_q[gp].found;
    assign s_index[gp*IDXW +: IDXW]  = res_q[gp].idx;
    assign s_ppn[gp*20 +: 20]        = res_q[gp].ppn;
    assign s_ps[gp*6 +: 6]           = res_q[gp].ps;
    assign s_plv[gp*2 +: 2]          = res_q[gp].plv;
    assign s_mat[gp*2 +: 2]          = res_q[gp].mat;
    assign s_d[gp]                   = res_q[gp].d;
    assign s_v[gp]                   = res_q[gp].v;
  end

  assign s_valid    = s_valid_q;
  assign r_valid    = r_valid_q;
  assign r_e        = r_e_q;
  assign r_vppn     = r_ent_q.vppn;
  assign r_ps       = r_ent_q.ps;
  assign r_asid     = r_ent_q.asid;
  assign r_g        = r_ent_q.g;
  assign r_ppn0     = r_ent_q.ppn0;
  assign r_plv0     = r_ent_q.plv0;
  assign r_mat0     = r_ent_q.mat0;
  assign r_d0       = r_ent_q.d0;
  assign r_v0       = r_ent_q.v0;
  assign r_ppn1     = r_ent_q.ppn1;
  assign r_plv1     = r_ent_q.plv1;
  assign r_mat1     = r_ent_q.mat1;
  assign r_d1       = r_ent_q.d1;
  assign r_v1       = r_ent_q.v1;
  assign fill_index = fill_index_q;
  assign invtlb_ill = invtlb_ill_q;

endmodule
